// File: rtl/keycode_dir_ctrl.sv
// ---------------------------------------------------------------------------
// keycode_dir_ctrl
//   Turns a raw USB HID keycode into sprite heading control for a tile game.
//   The keycode is debounced, each newly accepted mapped key makes one press
//   event, direction presses queue a turn with a timeout, and a pause key
//   toggles a freeze of movement. Movement is advanced on frame_tick.
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset         in   synchronous active-high reset
//   keycode       in   8-bit HID keycode, 0x00 = no key
//   frame_tick    in   one-cycle pulse per movement step
//   can_turn      in   neighbour walkability {right,left,down,up}
//   dir           out  heading: 00 up, 01 down, 10 left, 11 right
//   moving        out  sprite advances along dir
//   pending_valid out  a queued turn is waiting
//   pending_dir   out  queued direction (same encoding as dir)
//   paused        out  pause state
// ---------------------------------------------------------------------------
module keycode_dir_ctrl #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned TURN_TIMEOUT  = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic [3:0] can_turn,
  output logic [1:0] dir,
  output logic       moving,
  output logic       pending_valid,
  output logic [1:0] pending_dir,
  output logic       paused
);

  localparam logic [7:0] STABLE_MAX   = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0] TIMEOUT_INIT = 4'(TURN_TIMEOUT);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Debounce state
  logic [7:0] sample_q, sample_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;

  // Control state
  logic [1:0] dir_q, dir_d;
  logic       moving_q, moving_d;
  logic       pv_q, pv_d;
  logic [1:0] pd_q, pd_d;
  logic       paused_q, paused_d;
  logic [3:0] to_q, to_d;

  // Decode of the code being accepted this cycle
  logic       dec_is_dir;
  logic       dec_is_pause;
  logic [1:0] dec_dir;
  logic       dir_evt;
  logic       pause_evt;
  logic       tick_live;

  always_comb begin
    dec_is_dir   = 1'b0;
    dec_is_pause = 1'b0;
    dec_dir      = DIR_UP;
    case (acc_d)
      8'h1A, 8'h52: begin dec_is_dir = 1'b1; dec_dir = DIR_UP;    end
      8'h16, 8'h51: begin dec_is_dir = 1'b1; dec_dir = DIR_DOWN;  end
      8'h04, 8'h50: begin dec_is_dir = 1'b1; dec_dir = DIR_LEFT;  end
      8'h07, 8'h4F: begin dec_is_dir = 1'b1; dec_dir = DIR_RIGHT; end
      8'h2C:        dec_is_pause = 1'b1;
      default:      ;
    endcase
  end

  always_comb begin
    // Debounce: the incoming keycode is compared against the previously
    // registered sample, so cnt counts how many samples in a row match.
    sample_d = keycode;
    if (keycode != sample_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == STABLE_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    acc_d = (cnt_d == STABLE_MAX) ? keycode : acc_q;

    // A press only fires on a change of the accepted code, so a held key
    // gives exactly one event and re-accepting the same code gives none.
    dir_evt   = (acc_d != acc_q) && dec_is_dir;
    pause_evt = (acc_d != acc_q) && dec_is_pause;
    tick_live = frame_tick && !paused_q;

    dir_d    = dir_q;
    moving_d = moving_q;
    pv_d     = pv_q;
    pd_d     = pd_q;
    paused_d = paused_q ^ pause_evt;
    to_d     = to_q;

    // Tick evaluated on the old pending state.
    if (tick_live) begin
      if (pv_q && can_turn[pd_q]) begin
        dir_d    = pd_q;
        moving_d = 1'b1;
        pv_d     = 1'b0;
      end else begin
        moving_d = can_turn[dir_q];
        if (pv_q) begin
          to_d = to_q - 4'd1;
          if (to_q == 4'd1) pv_d = 1'b0;
        end
      end
    end

    // A new direction press overrides whatever the tick did to the queue.
    if (dir_evt) begin
      pv_d = 1'b1;
      pd_d = dec_dir;
      to_d = TIMEOUT_INIT;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sample_q <= 8'h00;
      cnt_q    <= 8'd0;
      acc_q    <= 8'h00;
      dir_q    <= DIR_LEFT;
      moving_q <= 1'b0;
      pv_q     <= 1'b0;
      pd_q     <= DIR_UP;
      paused_q <= 1'b0;
      to_q     <= 4'd0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      pv_q     <= pv_d;
      pd_q     <= pd_d;
      paused_q <= paused_d;
      to_q     <= to_d;
    end
  end

  assign dir           = dir_q;
  assign moving        = moving_q;
  assign pending_valid = pv_q;
  assign pending_dir   = pd_q;
  assign paused        = paused_q;

endmodule

// File: tb/tb_keycode_dir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keycode_dir_ctrl
//   Directed bench for keycode_dir_ctrl with default parameters
//   (STABLE_CYCLES=16, TURN_TIMEOUT=8). Inputs change 1 ns after a rising
//   edge and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_keycode_dir_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_tick;
  logic [3:0] can_turn;
  logic [1:0] dir;
  logic       moving;
  logic       pending_valid;
  logic [1:0] pending_dir;
  logic       paused;

  int checks   = 0;
  int failures = 0;

  keycode_dir_ctrl #(.STABLE_CYCLES(16), .TURN_TIMEOUT(8)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .frame_tick    (frame_tick),
    .can_turn      (can_turn),
    .dir           (dir),
    .moving        (moving),
    .pending_valid (pending_valid),
    .pending_dir   (pending_dir),
    .paused        (paused)
  );

  // Clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Checker
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hold_key(input logic [7:0] k, input int n);
    keycode = k;
    steps(n);
  endtask

  task automatic press(input logic [7:0] k);
    hold_key(k, 20);
    hold_key(8'h00, 20);
  endtask

  task automatic tick(input logic [3:0] ct);
    frame_tick = 1'b1;
    can_turn   = ct;
    step();
    frame_tick = 1'b0;
    can_turn   = 4'b0000;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dir"},    8'(dir),           8'h2);
    check({tag, "_moving"}, 8'(moving),        8'h0);
    check({tag, "_pv"},     8'(pending_valid), 8'h0);
    check({tag, "_pd"},     8'(pending_dir),   8'h0);
    check({tag, "_paused"}, 8'(paused),        8'h0);
  endtask

  initial begin
    Reset      = 1'b1;
    keycode    = 8'h00;
    frame_tick = 1'b0;
    can_turn   = 4'b0000;
    steps(2);
    Reset = 1'b0;
    check_reset_outputs("rst");

    // Up key: accepted on the 16th identical sample, not the 15th.
    keycode = 8'h1A;
    steps(15);
    check("up_15", 8'(pending_valid), 8'h0);
    step();
    check("up_16_pv", 8'(pending_valid), 8'h1);
    check("up_16_pd", 8'(pending_dir),   8'h0);
    steps(4);
    keycode = 8'h00;
    frame_tick = 1'b1;
    can_turn   = 4'b0001;
    step();
    frame_tick = 1'b0;
    check("up_turn_dir",    8'(dir),           8'h0);
    check("up_turn_moving", 8'(moving),        8'h1);
    check("up_turn_pv",     8'(pending_valid), 8'h0);
    steps(20);

    // Short right glitch is rejected; a long hold gives one event.
    hold_key(8'h07, 10);
    hold_key(8'h00, 20);
    check("short_pv", 8'(pending_valid), 8'h0);
    hold_key(8'h07, 20);
    check("right_pv", 8'(pending_valid), 8'h1);
    check("right_pd", 8'(pending_dir),   8'h3);
    frame_tick = 1'b1;
    can_turn   = 4'b1000;
    step();
    frame_tick = 1'b0;
    check("right_dir", 8'(dir), 8'h3);
    hold_key(8'h07, 80);
    check("held_once_pv", 8'(pending_valid), 8'h0);
    hold_key(8'h00, 20);

    // Timeout: back to left, queue right into a wall for 8 ticks.
    press(8'h04);
    tick(4'b0100);
    check("left_dir", 8'(dir), 8'h2);
    press(8'h07);
    check("q_right_pv", 8'(pending_valid), 8'h1);
    for (int i = 0; i < 7; i++) tick(4'b0100);
    check("to7_pv", 8'(pending_valid), 8'h1);
    tick(4'b0100);
    check("to8_pv",     8'(pending_valid), 8'h0);
    check("to8_dir",    8'(dir),           8'h2);
    check("to8_moving", 8'(moving),        8'h1);
    tick(4'b1000);
    check("to9_dir",    8'(dir),           8'h2);
    check("to9_moving", 8'(moving),        8'h0);

    // Pause freezes movement; pending still loads.
    press(8'h1A);
    check("p_up_pv", 8'(pending_valid), 8'h1);
    press(8'h2C);
    check("paused_on", 8'(paused), 8'h1);
    for (int i = 0; i < 5; i++) tick(4'b1111);
    check("frz_dir",    8'(dir),           8'h2);
    check("frz_moving", 8'(moving),        8'h0);
    check("frz_pv",     8'(pending_valid), 8'h1);
    check("frz_pd",     8'(pending_dir),   8'h0);
    press(8'h2C);
    check("paused_off", 8'(paused), 8'h0);
    tick(4'b1111);
    check("unp_dir",    8'(dir),           8'h0);
    check("unp_moving", 8'(moving),        8'h1);
    check("unp_pv",     8'(pending_valid), 8'h0);

    // Down event on the same edge as a tick taking pending left.
    press(8'h04);
    check("ql_pd", 8'(pending_dir), 8'h2);
    keycode = 8'h16;
    steps(15);
    frame_tick = 1'b1;
    can_turn   = 4'b0100;
    step();
    frame_tick = 1'b0;
    can_turn   = 4'b0000;
    keycode    = 8'h00;
    check("coin_dir",    8'(dir),           8'h2);
    check("coin_moving", 8'(moving),        8'h1);
    check("coin_pv",     8'(pending_valid), 8'h1);
    check("coin_pd",     8'(pending_dir),   8'h1);
    step();
    for (int i = 0; i < 7; i++) tick(4'b0000);
    check("coin_to7_pv", 8'(pending_valid), 8'h1);
    tick(4'b0000);
    check("coin_to8_pv", 8'(pending_valid), 8'h0);
    check("coin_to8_dir", 8'(dir), 8'h2);

    // Reset with everything active, key held through reset.
    tick(4'b0100);
    check("pre_moving", 8'(moving), 8'h1);
    press(8'h1A);
    press(8'h2C);
    check("pre_pv",     8'(pending_valid), 8'h1);
    check("pre_paused", 8'(paused),        8'h1);
    hold_key(8'h16, 10);
    Reset      = 1'b1;
    frame_tick = 1'b1;
    can_turn   = 4'b1111;
    step();
    Reset      = 1'b0;
    frame_tick = 1'b0;
    can_turn   = 4'b0000;
    check_reset_outputs("rst2");
    steps(15);
    check("rst_hold_15", 8'(pending_valid), 8'h0);
    step();
    check("rst_hold_16_pv", 8'(pending_valid), 8'h1);
    check("rst_hold_16_pd", 8'(pending_dir),   8'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keycode_dir_ctrl.md
KEYCODE_DIR_CTRL -- requirements
Module: keycode_dir_ctrl

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 16, the number of consecutive identical keycode samples required to accept a keycode (legal range 2..255).
REQ-002 The module SHALL have parameter TURN_TIMEOUT, default 8, the number of unpaused frame ticks a queued turn survives (legal range 1..15).
REQ-003 Port Clk  in  1  system clock; all logic on its rising edge.
REQ-004 Port Reset  in  1  synchronous, active-high reset.
REQ-005 Port keycode  in  8  USB HID keycode from the SoC keycode export; 0x00 means no key.
REQ-006 Port frame_tick  in  1  one-cycle pulse per game movement step.
REQ-007 Port can_turn  in  4  walkability of the neighbour tile per direction: bit0 up, bit1 down, bit2 left, bit3 right; valid whenever frame_tick=1.
REQ-008 Port dir  out  2  current heading: 00 up, 01 down, 10 left, 11 right.
REQ-009 Port moving  out  1  1 while the sprite advances along dir.
REQ-010 Port pending_valid  out  1  a queued turn is waiting.
REQ-011 Port pending_dir  out  2  queued direction; encoding as dir.
REQ-012 Port paused  out  1  game pause state.

Function
REQ-013 Debounce: keycode SHALL be registered each cycle; a saturating stable counter SHALL clear to 0 when the registered sample differs from the previous sample, else increment.
REQ-014 The accepted code acc_code SHALL update to the sample on the cycle the counter reaches STABLE_CYCLES-1; changes shorter than STABLE_CYCLES cycles SHALL never reach acc_code.
REQ-015 A press event SHALL be a one-cycle internal pulse, asserted when acc_code changes to a mapped code; a held key SHALL produce exactly one event, and release (0x00) SHALL produce none.
REQ-016 Mapping SHALL be: 0x1A/0x52 up; 0x16/0x51 down; 0x04/0x50 left; 0x07/0x4F right; 0x2C pause toggle; every other code SHALL be ignored.
REQ-017 A direction event SHALL set pending_valid=1, set pending_dir to the decoded direction, and load a 4-bit timeout counter with TURN_TIMEOUT, overwriting any earlier pending turn.
REQ-018 A pause event SHALL toggle paused.
REQ-019 While paused=1, frame_tick SHALL be ignored: dir, moving and the timeout SHALL be frozen, while debounce and pending loading continue.
REQ-020 On an unpaused frame_tick with pending_valid=1 and can_turn[pending_dir]=1: dir<=pending_dir, moving<=1, pending_valid<=0.
REQ-021 On an unpaused frame_tick with pending_valid=1 and can_turn[pending_dir]=0: the timeout SHALL decrement; if it was 1, pending_valid<=0.
REQ-022 On an unpaused frame_tick where no turn is taken: moving<=can_turn[dir].
REQ-023 On a direction event coinciding with frame_tick, the tick SHALL be evaluated on the old pending state, and the event's pending values SHALL take priority in the pending registers.
REQ-024 A turn into the reverse of dir SHALL receive no special treatment; it obeys REQ-020/021.
REQ-025 All outputs SHALL be registered; a turn SHALL be visible on dir the cycle after the frame_tick.

Reset
REQ-026 On Reset=1 at a clock edge: dir=10 (left), moving=0, pending_valid=0, pending_dir=00, paused=0, acc_code=0x00, stable counter=0, timeout=0, registered sample=0x00.
REQ-027 Reset SHALL take priority over all events, including a same-cycle frame_tick or press event.
REQ-028 Reset mid-debounce SHALL discard partial progress; a key held through reset SHALL need a full STABLE_CYCLES again after release of reset and SHALL then produce one event.

Verification
REQ-029 Reset, then keycode=0x1A for 20 cycles, then frame_tick with can_turn=0001 -> pending_valid=1, pending_dir=00 before the tick; dir=00, moving=1, pending_valid=0 one cycle after the tick.
REQ-030 keycode=0x07 for 10 cycles then 0x00 -> no event, pending_valid stays 0; 0x07 held 100 cycles -> exactly one event.
REQ-031 Queue right with can_turn=0100, then 8 frame_ticks -> dir stays 10, pending_valid drops to 0 after the 8th tick; a 9th tick with can_turn=1000 -> no turn.
REQ-032 Press 0x2C (paused=1), issue 5 frame_ticks with can_turn=1111 and pending up -> dir, moving and timeout unchanged; press 0x2C again -> paused=0, next tick takes the turn.
REQ-033 Down event on the same cycle as a frame_tick that takes a pending left -> dir=10 and pending_valid=1, pending_dir=01, timeout=TURN_TIMEOUT.
REQ-034 Reset asserted with pending_valid=1, paused=1, moving=1 -> next cycle all outputs equal the REQ-026 values.
